// File: rtl/fb_stream_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_stream_writer_if : decoded byte stream in, framebuffer/palette strobes out |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
interface fb_stream_writer_if #(
    parameter int FB_ADDR_W  = 15,
    parameter int PAL_ADDR_W = 4,
    parameter int COLOR_W    = 12
);
    logic                  in_sof;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  fb_we;
    logic [FB_ADDR_W-1:0]  fb_addr;
    logic [7:0]            fb_din;
    logic                  pal_we;
    logic [PAL_ADDR_W-1:0] pal_addr;
    logic [COLOR_W-1:0]    pal_din;
    logic                  busy;
    logic                  err;

    modport master (
        output in_sof, in_valid, in_data,
        input  in_ready, fb_we, fb_addr, fb_din, pal_we, pal_addr, pal_din, busy, err
    );

    modport slave (
        input  in_sof, in_valid, in_data,
        output in_ready, fb_we, fb_addr, fb_din, pal_we, pal_addr, pal_din, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/fb_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_stream_writer : command engine turning decoded bytes into RAM writes      |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module fb_stream_writer #(
    parameter int FB_ADDR_W  = 15,
    parameter int PAL_ADDR_W = 4,
    parameter int COLOR_W    = 12,
    parameter int FILL_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    fb_stream_writer_if.slave bus
);
    localparam int c_ADDR_BYTES = (FB_ADDR_W + 7) / 8;
    localparam int c_PAL_BYTES  = (COLOR_W + 7) / 8;
    localparam int c_AP_BYTES   = (c_ADDR_BYTES > c_PAL_BYTES) ? c_ADDR_BYTES : c_PAL_BYTES;
    // Shadow holds at least three bytes so the fill triple shares the same collector.
    localparam int c_SH_BYTES   = (c_AP_BYTES > 3) ? c_AP_BYTES : 3;
    localparam int c_SH_W       = 8 * c_SH_BYTES;
    localparam int c_CNT_W      = $clog2(c_SH_BYTES);

    typedef enum logic [2:0] {
        S_MODE   = 3'd0,
        S_DATA   = 3'd1,
        S_ADDR   = 3'd2,
        S_FILL   = 3'd3,
        S_PAL    = 3'd4,
        S_PALSEL = 3'd5,
        S_SKIP   = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_SH_W-1:0]     r_shadow;
    logic [FB_ADDR_W-1:0]  r_wr_addr;
    logic [FILL_CNT_W-1:0] r_fill_rem;
    logic                  r_fb_we;
    logic [FB_ADDR_W-1:0]  r_fb_addr;
    logic [7:0]            r_fb_din;
    logic                  r_pal_we;
    logic [PAL_ADDR_W-1:0] r_pal_addr;
    logic [COLOR_W-1:0]    r_pal_din;
    logic                  r_busy;
    logic                  r_err;
    logic                  r_ready;

    logic                  w_accept;
    state_t                w_state;
    logic [c_SH_W-1:0]     w_shadow;
    logic [FILL_CNT_W-1:0] w_fill_cnt;

    assign w_accept   = bus.in_valid && r_ready;
    assign w_state    = bus.in_sof ? S_MODE : r_state;
    assign w_fill_cnt = r_shadow[FILL_CNT_W-1:0];

    always_comb begin
        w_shadow = r_shadow;
        for (int i = 0; i < c_SH_BYTES; i++) begin
            if (r_cnt == i[c_CNT_W-1:0]) begin
                w_shadow[i*8 +: 8] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_MODE;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_wr_addr  <= '0;
            r_fill_rem <= '0;
            r_fb_we    <= 1'b0;
            r_fb_addr  <= '0;
            r_fb_din   <= '0;
            r_pal_we   <= 1'b0;
            r_pal_addr <= '0;
            r_pal_din  <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_fb_we  <= 1'b0;
            r_pal_we <= 1'b0;
            // The index advances after the strobe cycle so pal_addr is stable while pal_we is high.
            if (r_pal_we) begin
                r_pal_addr <= r_pal_addr + PAL_ADDR_W'(1);
            end

            if (bus.in_sof) begin
                r_state <= S_MODE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
                if (r_cnt != '0) begin
                    r_err <= 1'b1;
                end
            end else if (r_busy) begin
                if (r_fill_rem != '0) begin
                    r_fb_we    <= 1'b1;
                    r_fb_addr  <= r_wr_addr;
                    r_wr_addr  <= r_wr_addr + FB_ADDR_W'(1);
                    r_fill_rem <= r_fill_rem - FILL_CNT_W'(1);
                end else begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            end

            if (w_accept) begin
                case (w_state)
                    S_MODE: begin
                        r_cnt <= '0;
                        case (bus.in_data[2:0])
                            3'd1:    r_state <= S_DATA;
                            3'd2:    r_state <= S_ADDR;
                            3'd3:    r_state <= S_FILL;
                            3'd4:    r_state <= S_PAL;
                            3'd5:    r_state <= S_PALSEL;
                            default: begin
                                r_state <= S_SKIP;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                    S_DATA: begin
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= r_wr_addr;
                        r_fb_din  <= bus.in_data;
                        r_wr_addr <= r_wr_addr + FB_ADDR_W'(1);
                    end
                    S_ADDR: begin
                        r_shadow <= w_shadow;
                        if (r_cnt == c_CNT_W'(c_ADDR_BYTES - 1)) begin
                            r_wr_addr <= w_shadow[FB_ADDR_W-1:0];
                            r_cnt     <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_FILL: begin
                        if (r_cnt == c_CNT_W'(2)) begin
                            r_cnt <= '0;
                            if (w_fill_cnt != '0) begin
                                r_fb_we    <= 1'b1;
                                r_fb_addr  <= r_wr_addr;
                                r_fb_din   <= bus.in_data;
                                r_wr_addr  <= r_wr_addr + FB_ADDR_W'(1);
                                r_fill_rem <= w_fill_cnt - FILL_CNT_W'(1);
                                r_busy     <= 1'b1;
                                r_ready    <= 1'b0;
                            end
                        end else begin
                            r_shadow <= w_shadow;
                            r_cnt    <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_PAL: begin
                        r_shadow <= w_shadow;
                        if (r_cnt == c_CNT_W'(c_PAL_BYTES - 1)) begin
                            r_pal_we  <= 1'b1;
                            r_pal_din <= w_shadow[COLOR_W-1:0];
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    S_PALSEL: begin
                        r_pal_addr <= bus.in_data[PAL_ADDR_W-1:0];
                        r_state    <= S_PAL;
                    end
                    default: begin
                        r_state <= S_SKIP;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready = r_ready;
    assign bus.fb_we    = r_fb_we;
    assign bus.fb_addr  = r_fb_addr;
    assign bus.fb_din   = r_fb_din;
    assign bus.pal_we   = r_pal_we;
    assign bus.pal_addr = r_pal_addr;
    assign bus.pal_din  = r_pal_din;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
endmodule
`default_nettype wire
